// File: rtl/cassette_save_if.sv
// cassette_save_if: request, RAM read port and tape byte sink of the tape-image writer.
// The master modport is the writer itself; the slave modport is its environment.
interface cassette_save_if #(
    parameter int NAME_MAX = 8
);
    logic                  start;
    logic [7:0]            file_type;
    logic [8*NAME_MAX-1:0] name;
    logic [3:0]            name_len;
    logic [15:0]           load_addr;
    logic [15:0]           prog_len;
    logic                  mem_rd;
    logic [15:0]           mem_addr;
    logic [7:0]            mem_din;
    logic [7:0]            tape_dout;
    logic                  tape_valid;
    logic                  tape_ready;
    logic [24:0]           tape_addr;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, file_type, name, name_len, load_addr, prog_len, mem_din, tape_ready,
        output mem_rd, mem_addr, tape_dout, tape_valid, tape_addr, busy, done, error
    );

    modport slave (
        output start, file_type, name, name_len, load_addr, prog_len, mem_din, tape_ready,
        input  mem_rd, mem_addr, tape_dout, tape_valid, tape_addr, busy, done, error
    );
endinterface

// File: rtl/cassette_save.sv
// cassette_save: serialises a Lynx TAP image (quote, name, quote, type, length,
// [load], code, [check, trailer]) onto a valid/ready byte sink, reading code
// bytes from RAM through a 1-cycle-latency read port.
// Optional feature macro: CASSETTE_SAVE_LEADER_EN prepends LEADER_LEN bytes of
// 8'hA5 ahead of the first quote; they are counted in tape_addr.
module cassette_save #(
    parameter int         NAME_MAX   = 8,
    parameter logic [7:0] TRAILER    = 8'h00,
    parameter int         LEADER_LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    cassette_save_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEADER, S_QUOTE1, S_NAME, S_QUOTE2, S_FTYPE, S_LENLO, S_LENHI,
        S_LOADLO, S_LOADHI, S_FETCH, S_LATCH, S_CODE, S_CHECK, S_TRAIL, S_DONE
    } state_t;

    state_t                state;
    state_t                hdr_next;
    logic [7:0]            hdr_byte;
    logic [3:0]            next_idx;
    logic [7:0]            chk_next;
    logic [8*NAME_MAX-1:0] name_r;
    logic [3:0]            nlen;
    logic [3:0]            name_idx;
    logic [7:0]            ftype;
    logic                  is_md;
    logic [15:0]           remain;
    logic [15:0]           ptr;
    logic [7:0]            chk;
    logic [7:0]            tape_dout;
    logic                  tape_valid;
    logic [24:0]           tape_addr;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  accept;
    logic                  mem_rd;
`ifdef CASSETTE_SAVE_LEADER_EN
    logic [15:0]           lead_cnt;
`else
    logic                  unused_leader;
    assign unused_leader = (LEADER_LEN != 0);
`endif

    // Name length saturates at the configured maximum.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (int'(len) > NAME_MAX) ? 4'(NAME_MAX) : len;
    endfunction

    // Check digit is the plain 8-bit sum of the code bytes.
    function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic type_known(input logic [7:0] ft);
        return (ft == 8'h42) || (ft == 8'h4D) || (ft == 8'h44) || (ft == 8'h41);
    endfunction

    assign accept = tape_valid && bus.tape_ready;
    // A fetch goes out on entry to the code loop and again on every accepted
    // code byte that is not the last, so a byte can move every 2 cycles.
    assign mem_rd = (state == S_FETCH) || (state == S_CODE && accept && remain != 16'd1);

    assign bus.mem_rd     = mem_rd;
    assign bus.mem_addr   = ptr;
    assign bus.tape_dout  = tape_dout;
    assign bus.tape_valid = tape_valid;
    assign bus.tape_addr  = tape_addr;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;

    // Successor of the current byte-emitting state and the byte it presents.
    always_comb begin
        hdr_next = S_DONE;
        next_idx = 4'd0;
        hdr_byte = 8'h00;
        chk_next = (state == S_CODE) ? add_mod256(chk, tape_dout) : chk;
        case (state)
`ifdef CASSETTE_SAVE_LEADER_EN
            S_LEADER: hdr_next = (lead_cnt == 16'(LEADER_LEN - 1)) ? S_QUOTE1 : S_LEADER;
`endif
            S_QUOTE1: hdr_next = (nlen != 4'd0) ? S_NAME : S_QUOTE2;
            S_NAME: begin
                next_idx = name_idx + 4'd1;
                hdr_next = (next_idx == nlen) ? S_QUOTE2 : S_NAME;
            end
            S_QUOTE2: hdr_next = S_FTYPE;
            S_FTYPE:  hdr_next = S_LENLO;
            S_LENLO:  hdr_next = S_LENHI;
            S_LENHI:  hdr_next = is_md ? S_LOADLO : ((remain == 16'd0) ? S_DONE : S_FETCH);
            S_LOADLO: hdr_next = S_LOADHI;
            S_LOADHI: hdr_next = (remain == 16'd0) ? S_CHECK : S_FETCH;
            S_CODE:   hdr_next = is_md ? S_CHECK : S_DONE;
            S_CHECK:  hdr_next = S_TRAIL;
            default:  hdr_next = S_DONE;
        endcase
        case (hdr_next)
            S_LEADER:           hdr_byte = 8'hA5;
            S_QUOTE1, S_QUOTE2: hdr_byte = 8'h22;
            S_NAME:             hdr_byte = name_r[8*int'(next_idx) +: 8];
            S_FTYPE:            hdr_byte = ftype;
            S_LENLO:            hdr_byte = remain[7:0];
            S_LENHI:            hdr_byte = remain[15:8];
            S_LOADLO:           hdr_byte = ptr[7:0];
            S_LOADHI:           hdr_byte = ptr[15:8];
            S_CHECK:            hdr_byte = chk_next;
            S_TRAIL:            hdr_byte = TRAILER;
            default:            hdr_byte = 8'h00;
        endcase
    end

    // Writer FSM: request capture, byte sequencing, code fetch loop and completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tape_dout  <= 8'h00;
            tape_valid <= 1'b0;
            tape_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ptr        <= 16'h0000;
            chk        <= 8'h00;
`ifdef CASSETTE_SAVE_LEADER_EN
            lead_cnt   <= 16'd0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (mem_rd) ptr <= ptr + 16'd1;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (type_known(bus.file_type)) begin
                            name_r     <= bus.name;
                            nlen       <= clamp_len(bus.name_len);
                            name_idx   <= 4'd0;
                            ftype      <= bus.file_type;
                            is_md      <= (bus.file_type == 8'h4D) || (bus.file_type == 8'h44);
                            remain     <= bus.prog_len;
                            ptr        <= bus.load_addr;
                            chk        <= 8'h00;
                            busy       <= 1'b1;
                            tape_valid <= 1'b1;
                            tape_addr  <= '0;
`ifdef CASSETTE_SAVE_LEADER_EN
                            lead_cnt   <= 16'd0;
                            state      <= S_LEADER;
                            tape_dout  <= 8'hA5;
`else
                            state      <= S_QUOTE1;
                            tape_dout  <= 8'h22;
`endif
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    tape_dout  <= bus.mem_din;
                    tape_valid <= 1'b1;
                    state      <= S_CODE;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (accept) begin
                        tape_addr <= tape_addr + 25'd1;
`ifdef CASSETTE_SAVE_LEADER_EN
                        if (state == S_LEADER) lead_cnt <= lead_cnt + 16'd1;
`endif
                        if (state == S_CODE) begin
                            chk    <= chk_next;
                            remain <= remain - 16'd1;
                        end
                        if (state == S_CODE && remain != 16'd1) begin
                            tape_valid <= 1'b0;
                            state      <= S_LATCH;
                        end else begin
                            state     <= hdr_next;
                            tape_dout <= hdr_byte;
                            name_idx  <= next_idx;
                            if (hdr_next == S_FETCH) begin
                                tape_valid <= 1'b0;
                            end else if (hdr_next == S_DONE) begin
                                tape_valid <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cassette_save.sv
// tb_cassette_save: directed and randomized runs of the tape-image writer
// against a byte-list reference model of the TAP image.
module tb_cassette_save;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cassette_save_if #(.NAME_MAX(8)) bus ();

    cassette_save #(.NAME_MAX(8), .TRAILER(8'h00), .LEADER_LEN(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;   // 0: always ready, 1: 3 stall cycles per byte, 2: random
    logic [7:0]  ram [0:65535];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  got_q[$];
    logic [24:0] got_addr_q[$];
    logic [15:0] rd_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_dout  = 8'h00;
    logic [24:0] prev_addr  = '0;

    // RAM with one cycle of read latency
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_din <= ram[bus.mem_addr];
    end

    // Sink ready pattern
    initial begin : ready_drv
        int cnt;
        cnt = 0;
        bus.tape_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                if (bus.tape_valid && cnt < 3) begin
                    bus.tape_ready = 1'b0;
                    cnt++;
                end else if (bus.tape_valid) begin
                    bus.tape_ready = 1'b1;
                    cnt = 0;
                end else begin
                    bus.tape_ready = 1'b0;
                end
            end else if (rdy_mode == 2) begin
                bus.tape_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.tape_ready = 1'b1;
            end
        end
    end

    // Observe accepted bytes, reads, pulses and stall stability mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.tape_valid && bus.tape_ready) begin
                got_q.push_back(bus.tape_dout);
                got_addr_q.push_back(bus.tape_addr);
            end
            if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
            if (bus.done) done_cnt++;
            if (bus.error) err_cnt++;
            if (prev_stall && !(bus.tape_valid && bus.tape_dout == prev_dout && bus.tape_addr == prev_addr))
                hold_err++;
            prev_stall = bus.tape_valid && !bus.tape_ready;
            prev_dout  = bus.tape_dout;
            prev_addr  = bus.tape_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference image built straight from the TAP layout
    task automatic build_exp(input logic [7:0] ft, input logic [63:0] nm, input logic [3:0] nl,
                             input logic [15:0] ld, input logic [15:0] ln);
        int nchars;
        logic [7:0] sum;
        logic [15:0] a;
        bit md;
        exp_q.delete();
        exp_rd.delete();
        md = (ft == 8'h4D) || (ft == 8'h44);
`ifdef CASSETTE_SAVE_LEADER_EN
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(8'h22);
        nchars = (int'(nl) > 8) ? 8 : int'(nl);
        for (int i = 0; i < nchars; i++) exp_q.push_back(nm[8*i +: 8]);
        exp_q.push_back(8'h22);
        exp_q.push_back(ft);
        exp_q.push_back(ln[7:0]);
        exp_q.push_back(ln[15:8]);
        if (md) begin
            exp_q.push_back(ld[7:0]);
            exp_q.push_back(ld[15:8]);
        end
        sum = 8'h00;
        for (int i = 0; i < int'(ln); i++) begin
            a = ld + 16'(i);
            exp_rd.push_back(a);
            exp_q.push_back(ram[a]);
            sum = sum + ram[a];
        end
        if (md) begin
            exp_q.push_back(sum);
            exp_q.push_back(8'h00);
        end
    endtask

    task automatic pulse_start(input logic [7:0] ft, input logic [63:0] nm, input logic [3:0] nl,
                               input logic [15:0] ld, input logic [15:0] ln);
        @(posedge clk);
        #1;
        bus.file_type = ft;
        bus.name      = nm;
        bus.name_len  = nl;
        bus.load_addr = ld;
        bus.prog_len  = ln;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] ft, input logic [63:0] nm, input logic [3:0] nl,
                       input logic [15:0] ld, input logic [15:0] ln, input bit poke);
        int gb, rb, db, eb, hb, n;
        bit seen;
        build_exp(ft, nm, nl, ld, ln);
        gb = got_q.size();
        rb = rd_q.size();
        db = done_cnt;
        eb = err_cnt;
        hb = hold_err;
        pulse_start(ft, nm, nl, ld, ln);
        check({tag, ":busy"}, 32'(bus.busy), 32'd1);
        if (poke) begin
            repeat (2) @(posedge clk);
            pulse_start(8'h5A, 64'h0, 4'd1, 16'h1234, 16'h0001);
        end
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (done_cnt != db) seen = 1'b1;
        end
        check({tag, ":done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, ":done_pulses"}, 32'(done_cnt - db), 32'd1);
        check({tag, ":busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, ":error_pulses"}, 32'(err_cnt - eb), 32'd0);
        check({tag, ":hold"}, 32'(hold_err - hb), 32'd0);
        check({tag, ":nbytes"}, 32'(got_q.size() - gb), 32'(exp_q.size()));
        n = (got_q.size() - gb < exp_q.size()) ? got_q.size() - gb : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:byte%0d", tag, i), 32'(got_q[gb + i]), 32'(exp_q[i]));
            check($sformatf("%s:addr%0d", tag, i), 32'(got_addr_q[gb + i]), 32'(i));
        end
        check({tag, ":nreads"}, 32'(rd_q.size() - rb), 32'(exp_rd.size()));
        n = (rd_q.size() - rb < exp_rd.size()) ? rd_q.size() - rb : exp_rd.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s:rd%0d", tag, i), 32'(rd_q[rb + i]), 32'(exp_rd[i]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ":tape_valid"}, 32'(bus.tape_valid), 32'd0);
        check({tag, ":tape_dout"},  32'(bus.tape_dout),  32'd0);
        check({tag, ":tape_addr"},  32'(bus.tape_addr),  32'd0);
        check({tag, ":mem_rd"},     32'(bus.mem_rd),     32'd0);
        check({tag, ":mem_addr"},   32'(bus.mem_addr),   32'd0);
        check({tag, ":busy"},       32'(bus.busy),       32'd0);
        check({tag, ":done"},       32'(bus.done),       32'd0);
        check({tag, ":error"},      32'(bus.error),      32'd0);
    endtask

    initial begin : main
        int gb, rb, db, eb, wait_c;
        logic [7:0] types [4];
        types[0] = 8'h42; types[1] = 8'h4D; types[2] = 8'h44; types[3] = 8'h41;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.file_type = 8'h00;
        bus.name = '0;
        bus.name_len = 4'd0;
        bus.load_addr = 16'h0000;
        bus.prog_len = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // B "AB", 3 code bytes
        ram[16'h694D] = 8'h01; ram[16'h694E] = 8'h02; ram[16'h694F] = 8'h03;
        run("b_ab", 8'h42, 64'h4241, 4'd2, 16'h694D, 16'd3, 1'b0);

        // M, empty name, checksum wraps to 05
        ram[16'h8000] = 8'h10; ram[16'h8001] = 8'hF5;
        gb = got_q.size();
        run("m_wrap", 8'h4D, 64'h0, 4'd0, 16'h8000, 16'd2, 1'b0);
`ifdef CASSETTE_SAVE_LEADER_EN
        check("m_wrap:first_quote", 32'(got_q[gb + 16]), 32'h22);
        check("m_wrap:first_quote_addr", 32'(got_addr_q[gb + 16]), 32'd16);
        check("m_wrap:chk_lit", 32'(got_q[gb + 25]), 32'h05);
`else
        check("m_wrap:chk_lit", 32'(got_q[gb + 9]), 32'h05);
`endif

        // M across the 16-bit address wrap, with a start pulse while busy
        ram[16'hFFFF] = 8'h80; ram[16'h0000] = 8'h81;
        run("m_addrwrap", 8'h4D, 64'h43, 4'd1, 16'hFFFF, 16'd2, 1'b1);

        // D with no code bytes
        run("d_len0", 8'h44, 64'h0, 4'd0, 16'h1234, 16'd0, 1'b0);

        // B "AB" again with 3 stall cycles on every byte
        rdy_mode = 1;
        run("b_stall", 8'h42, 64'h4241, 4'd2, 16'h694D, 16'd3, 1'b0);
        rdy_mode = 0;

        // Unknown file type
        eb = err_cnt;
        gb = got_q.size();
        pulse_start(8'h5A, 64'h41, 4'd1, 16'h0000, 16'd4);
        check("bad_type:error_now", 32'(bus.error), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("bad_type:error_pulses", 32'(err_cnt - eb), 32'd1);
        check("bad_type:no_bytes", 32'(got_q.size() - gb), 32'd0);
        check("bad_type:tape_valid", 32'(bus.tape_valid), 32'd0);
        check("bad_type:busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of the code loop
        rb = rd_q.size();
        pulse_start(8'h42, 64'h0, 4'd0, 16'h0100, 16'd20);
        wait_c = 0;
        while (rd_q.size() - rb < 3 && wait_c < 500) begin
            @(negedge clk);
            wait_c++;
        end
        check("mid_reset:reached_code", 32'(rd_q.size() - rb >= 3), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        db = done_cnt;
        @(posedge clk);
        #1;
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_reset:no_done", 32'(done_cnt - db), 32'd0);
        check("mid_reset:idle", 32'(bus.busy), 32'd0);

        // Randomized requests under random back-pressure
        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            run($sformatf("rnd%0d", t), types[$urandom_range(0, 3)], {$urandom, $urandom},
                4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom_range(0, 24)), 1'b0);
        end
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
